// File: rtl/ram_port_arbiter.sv
// Round-robin owner of a single-port RAM shared by two requesters; grant takes 1 cycle from idle, owner handoff has no bubble.
// Requesters hold req until ack; ownership is forcibly yielded after MAX_BURST acks while the other side waits.
module ram_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [1:0]        owner,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_mode,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          prefer1_q, prefer1_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [BW-1:0] burst_sat;
  logic          last_beat;
  logic          ram_mode_raw;

  // Count saturates so an uncontested owner can keep the RAM indefinitely.
  assign burst_sat = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
  assign last_beat = (burst_q >= BURST_LAST);

  always_comb begin
    state_d      = state_q;
    prefer1_d    = prefer1_q;
    burst_d      = burst_q;
    ack0         = 1'b0;
    ack1         = 1'b0;
    ram_mode_raw = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = prefer1_q ? OWN1 : OWN0;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end

      OWN0: begin
        ram_addr     = addr0;
        ram_din      = wdata0;
        ram_mode_raw = req0 & we0;
        ack0         = req0;
        if (!req0) begin
          burst_d = '0;
          state_d = req1 ? OWN1 : IDLE;
        end else if (last_beat && req1) begin
          burst_d = '0;
          state_d = OWN1;
        end else begin
          burst_d = burst_sat;
        end
      end

      OWN1: begin
        ram_addr     = addr1;
        ram_din      = wdata1;
        ram_mode_raw = req1 & we1;
        ack1         = req1;
        if (!req1) begin
          burst_d = '0;
          state_d = req0 ? OWN0 : IDLE;
        end else if (last_beat && req0) begin
          burst_d = '0;
          state_d = OWN0;
        end else begin
          burst_d = burst_sat;
        end
      end

      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase

    // Pointer remembers who was served last so the other wins the next tie.
    if (state_d == OWN0 && state_q != OWN0) prefer1_d = 1'b1;
    if (state_d == OWN1 && state_q != OWN1) prefer1_d = 1'b0;
  end

  // A write must never land on an edge that coincides with reset.
  assign ram_mode = ram_mode_raw & rst_n;
  assign owner    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prefer1_q <= 1'b0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      prefer1_q <= prefer1_d;
      burst_q   <= burst_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= ack0 & ~we0;
      rvalid1 <= ack1 & ~we1;
      if (ack0 && !we0) rdata0 <= ram_dout;
      if (ack1 && !we1) rdata1 <= ram_dout;
    end
  end

endmodule
